// File: rtl/ara_soul_bram_responder_pkg.sv
// Shared constants, FSM state type and address helper for the
// on-chip soul-memory responder.
package ara_soul_bram_responder_pkg;

  localparam int ARA_ROWS       = 3;
  localparam int ARA_DIM        = 64;
  localparam int ARA_CHUNK_BITS = 16;
  localparam int ARA_ACC_WIDTH  = 4;

  localparam int CPR    = ARA_DIM / ARA_CHUNK_BITS;
  localparam int DEPTH  = ARA_ROWS * CPR;
  localparam int WORD_W = ARA_CHUNK_BITS * (ARA_ACC_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_WR_DONE
  } resp_state_t;

  function automatic int row_chunk_to_addr(
    input int row,
    input int chunk,
    input int cpr
  );
    return row * cpr + chunk;
  endfunction

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ara_soul_bram_responder_if.sv
// Chunked soul-memory bus: master = controller, slave = responder.
// req/ready handshake plus row/chunk address and core/accum data.
interface ara_soul_bram_responder_if
  import ara_soul_bram_responder_pkg::*;
#(
  parameter int ROWS       = ARA_ROWS,
  parameter int DIM        = ARA_DIM,
  parameter int CHUNK_BITS = ARA_CHUNK_BITS,
  parameter int ACC_WIDTH  = ARA_ACC_WIDTH
);
  localparam int RW = clog2_min1(ROWS);
  localparam int CW = clog2_min1(DIM / CHUNK_BITS);
  localparam int AC = CHUNK_BITS * ACC_WIDTH;

  logic            mem_req;
  logic            mem_ready;
  logic [RW-1:0]   mem_row_addr;
  logic [CW-1:0]   mem_chunk_addr;
  logic            mem_we;
  logic [CHUNK_BITS-1:0] mem_core_out;
  logic [AC-1:0]   mem_accum_out;
  logic [CHUNK_BITS-1:0] mem_core_in;
  logic [AC-1:0]   mem_accum_in;

  modport master (
    output mem_req, mem_row_addr, mem_chunk_addr,
    output mem_we, mem_core_out, mem_accum_out,
    input  mem_ready, mem_core_in, mem_accum_in
  );

  modport slave (
    input  mem_req, mem_row_addr, mem_chunk_addr,
    input  mem_we, mem_core_out, mem_accum_out,
    output mem_ready, mem_core_in, mem_accum_in
  );

endinterface

// File: rtl/ara_soul_bram_responder_sdp_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
// Ports: we/waddr/wdata write; re/raddr in, rdata valid next cycle.
module ara_soul_bram_responder_sdp_ram #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  (* ram_style = "block" *)
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ara_soul_bram_responder.sv
// Soul-memory responder: clear sweep, req/ready FSM, range check.
// Ports: clk, rst_n, bus (slave), init_done, addr_err, proto_err.
module ara_soul_bram_responder
  import ara_soul_bram_responder_pkg::*;
#(
  parameter int ROWS       = ARA_ROWS,
  parameter int DIM        = ARA_DIM,
  parameter int CHUNK_BITS = ARA_CHUNK_BITS,
  parameter int ACC_WIDTH  = ARA_ACC_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  ara_soul_bram_responder_if.slave bus,
  output logic init_done,
  output logic addr_err,
  output logic proto_err
);

  localparam int N_CPR   = DIM / CHUNK_BITS;
  localparam int N_DEPTH = ROWS * N_CPR;
  localparam int W_ACC   = CHUNK_BITS * ACC_WIDTH;
  localparam int W_WORD  = CHUNK_BITS + W_ACC;
  localparam int AW      = clog2_min1(N_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(N_DEPTH - 1);

  resp_state_t       state, state_nx;
  logic [AW-1:0]     sweep;
  logic              ok_q;
  logic [W_WORD-1:0] hold_q, rd_q, rd_word, out_word;
  logic [W_WORD-1:0] wr_data;
  logic [AW-1:0]     req_addr, wr_addr;
  logic              in_range, accept, wr_en, rd_en;
  logic              rd_take, proto_set;

  always_comb begin
    in_range = (int'(bus.mem_row_addr) < ROWS)
            && (int'(bus.mem_chunk_addr) < N_CPR);
    req_addr = '0;
    if (in_range)
      req_addr = AW'(row_chunk_to_addr(int'(bus.mem_row_addr),
                                       int'(bus.mem_chunk_addr),
                                       N_CPR));
    accept  = (state == ST_IDLE) && bus.mem_req;
    // Sweep owns the write port until the clear completes.
    wr_en   = (state == ST_INIT) || (accept && bus.mem_we && in_range);
    wr_addr = (state == ST_INIT) ? sweep : req_addr;
    wr_data = (state == ST_INIT) ? '0
            : {bus.mem_accum_out, bus.mem_core_out};
    rd_en   = accept && !bus.mem_we;
    rd_word = ok_q ? rd_q : '0;
    rd_take = (state == ST_RD_DONE) && bus.mem_req;
    out_word = rd_take ? rd_word : hold_q;
  end

  always_comb begin
    state_nx  = state;
    proto_set = 1'b0;
    unique case (state)
      ST_INIT: if (sweep == LAST) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (bus.mem_req)
          state_nx = bus.mem_we ? ST_WR_DONE : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.mem_req) begin
          state_nx = ST_RD_DONE;
        end else begin
          state_nx  = ST_IDLE;
          proto_set = 1'b1;
        end
      end
      ST_RD_DONE, ST_WR_DONE: begin
        state_nx  = ST_IDLE;
        proto_set = !bus.mem_req;
      end
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep     <= '0;
      init_done <= 1'b0;
      addr_err  <= 1'b0;
      proto_err <= 1'b0;
      ok_q      <= 1'b0;
      hold_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_INIT) sweep <= sweep + AW'(1);
      if (state == ST_INIT && sweep == LAST) init_done <= 1'b1;
      if (accept) begin
        ok_q <= in_range;
        if (!in_range) addr_err <= 1'b1;
      end
      if (proto_set) proto_err <= 1'b1;
      if (rd_take) hold_q <= rd_word;
    end
  end

  assign bus.mem_ready = bus.mem_req
                      && (state == ST_RD_DONE || state == ST_WR_DONE);
  assign bus.mem_core_in  = out_word[CHUNK_BITS-1:0];
  assign bus.mem_accum_in = out_word[W_WORD-1:CHUNK_BITS];

  ara_soul_bram_responder_sdp_ram #(
    .WIDTH (W_WORD),
    .DEPTH (N_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (req_addr),
    .rdata (rd_q)
  );

endmodule
